// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift-register sequencer:
// mode-select op encodings and the sequencer FSM states.
package usr_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_ROR  = 2'b01;
  localparam logic [1:0] OP_ROL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/usr_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; a push while full or a
// pop while empty is ignored, so the contents are never corrupted.
module usr_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_data   = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/usr_sequencer.sv
// Queues {op, cnt, data} commands and replays each one as mode select and
// parallel data for a universal shift register, one command at a time.
module usr_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [3:0]       cmd_data,
  output logic             s1,
  output logic             s0,
  output logic [3:0]       p_in,
  output logic             busy,
  output logic             done
);

  import usr_pkg::*;

  localparam int ENTRY_W = 2 + CNT_W + 4;

  state_t             r_state;
  state_t             w_nextState;
  logic [1:0]         r_op;
  logic [1:0]         r_sel;
  logic [1:0]         w_selNext;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntNext;
  logic [CNT_W-1:0]   w_effCnt;
  logic [3:0]         r_pIn;
  logic [3:0]         w_pInNext;
  logic               r_done;
  logic               w_doneNext;
  logic [ENTRY_W-1:0] w_head;
  logic [1:0]         w_headOp;
  logic [CNT_W-1:0]   w_headCnt;
  logic [3:0]         w_headData;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;

  usr_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (cmd_valid),
    .i_data  ({cmd_op, cmd_cnt, cmd_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign cmd_ready = !w_full;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;
  assign {w_headOp, w_headCnt, w_headData} = w_head;
  // A parallel load is a single-cycle action regardless of its count field.
  assign w_effCnt  = (w_headOp == OP_LOAD) ? CNT_W'(1) : w_headCnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_pop) w_nextState = (w_effCnt != '0) ? ST_RUN : ST_DONE;
      ST_RUN:  if (r_cnt <= CNT_W'(1)) w_nextState = ST_DONE;
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line
  // up with the state they describe.
  always_comb begin
    w_selNext  = OP_HOLD;
    w_pInNext  = r_pIn;
    w_cntNext  = r_cnt;
    w_doneNext = (w_nextState == ST_DONE);
    if (w_pop) begin
      w_pInNext = w_headData;
      w_cntNext = w_effCnt;
    end else if (r_state == ST_RUN && r_cnt != '0) begin
      w_cntNext = r_cnt - CNT_W'(1);
    end
    if (w_nextState == ST_RUN) w_selNext = w_pop ? w_headOp : r_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= OP_HOLD;
      r_sel  <= OP_HOLD;
      r_cnt  <= '0;
      r_pIn  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_pop) r_op <= w_headOp;
      r_sel  <= w_selNext;
      r_cnt  <= w_cntNext;
      r_pIn  <= w_pInNext;
      r_done <= w_doneNext;
    end
  end

  assign {s1, s0} = r_sel;
  assign p_in     = r_pIn;
  assign done     = r_done;
  assign busy     = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_usr_sequencer.sv
// Self-checking bench for usr_sequencer: a schedule model predicts, per cycle,
// the mode select, parallel data, done, busy and ready from accepted commands.
module tb_usr_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic       s1;
  logic       s0;
  logic [3:0] p_in;
  logic       busy;
  logic       done;

  int testsRun = 0;
  int testsFailed = 0;

  // Model: one entry per accepted command with its push and pop cycles.
  int         cyc;
  int         nextFree;
  int         qPush[$];
  int         qPop[$];
  int         qEff[$];
  logic [1:0] qOp[$];
  logic [3:0] qData[$];
  logic [3:0] usrQ;
  int         doneSeen;

  always #5 clk = ~clk;

  usr_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_data  (cmd_data),
    .s1        (s1),
    .s0        (s0),
    .p_in      (p_in),
    .busy      (busy),
    .done      (done)
  );

  function automatic int occupancy(int k);
    int n = 0;
    foreach (qPush[i]) if (qPush[i] < k && qPop[i] >= k) n++;
    return n;
  endfunction

  function automatic logic expReady(int k);
    return occupancy(k) < DEPTH;
  endfunction

  function automatic logic [1:0] expSel(int k);
    logic [1:0] r = 2'b00;
    foreach (qPop[i]) if (k > qPop[i] && k <= qPop[i] + qEff[i]) r = qOp[i];
    return r;
  endfunction

  function automatic logic [3:0] expP(int k);
    logic [3:0] r = 4'h0;
    foreach (qPop[i]) if (qPop[i] < k) r = qData[i];
    return r;
  endfunction

  function automatic logic expDone(int k);
    logic r = 1'b0;
    foreach (qPop[i]) if (k == qPop[i] + qEff[i] + 1) r = 1'b1;
    return r;
  endfunction

  function automatic logic expBusy(int k);
    logic r = 1'b0;
    foreach (qPop[i]) if (k > qPush[i] && k <= qPop[i] + qEff[i] + 1) r = 1'b1;
    return r;
  endfunction

  task automatic doReset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_cnt = 4'h0;
    cmd_data = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    qPush.delete(); qPop.delete(); qEff.delete(); qOp.delete(); qData.delete();
    cyc = 0;
    nextFree = 0;
    usrQ = 4'h0;
    doneSeen = 0;
  endtask

  // Offers a command for one cycle, feeds a behavioural shift register from
  // the current outputs, and records the command if the model accepts it.
  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] cnt,
                       input logic [3:0] data, output logic acc);
    int eff;
    int pop;
    if (done === 1'b1) doneSeen++;
    case ({s1, s0})
      2'b01:   usrQ = {usrQ[0], usrQ[3:1]};
      2'b10:   usrQ = {usrQ[2:0], usrQ[3]};
      2'b11:   usrQ = p_in;
      default: usrQ = usrQ;
    endcase
    cmd_valid = v;
    cmd_op = op;
    cmd_cnt = cnt;
    cmd_data = data;
    acc = v && expReady(cyc);
    if (acc) begin
      eff = (op == 2'b11) ? 1 : int'(cnt);
      pop = (cyc + 1 > nextFree) ? cyc + 1 : nextFree;
      qPush.push_back(cyc); qPop.push_back(pop); qEff.push_back(eff);
      qOp.push_back(op); qData.push_back(data);
      nextFree = pop + eff + 2;
    end
    @(posedge clk); #1;
    cyc++;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    testsRun++; if ({s1, s0} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_sel: got %b expected 00", {s1, s0}); end
    testsRun++; if (p_in !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_pin: got %b expected 0000", p_in); end
    testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    testsRun++; if (cmd_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_load();
    logic acc;
    doReset();
    drive(1'b1, 2'b11, 4'($urandom_range(0, 15)), 4'b1011, acc);
    repeat (5) begin
      testsRun++; if ({s1, s0} !== expSel(cyc)) begin testsFailed++; $display("[TB] FAIL load_sel c%0d: got %b expected %b", cyc, {s1, s0}, expSel(cyc)); end
      testsRun++; if (p_in !== expP(cyc)) begin testsFailed++; $display("[TB] FAIL load_pin c%0d: got %b expected %b", cyc, p_in, expP(cyc)); end
      testsRun++; if (done !== expDone(cyc)) begin testsFailed++; $display("[TB] FAIL load_done c%0d: got %b expected %b", cyc, done, expDone(cyc)); end
      drive(1'b0, 2'b00, 4'h0, 4'h0, acc);
    end
    testsRun++; if (usrQ !== 4'b1011) begin testsFailed++; $display("[TB] FAIL load_usr: got %b expected 1011", usrQ); end
    testsRun++; if (doneSeen != 1) begin testsFailed++; $display("[TB] FAIL load_donecount: got %0d expected 1", doneSeen); end
  endtask

  task automatic test_rotate();
    logic acc;
    int runCount = 0;
    doReset();
    drive(1'b1, 2'b11, 4'($urandom_range(0, 15)), 4'b1000, acc);
    drive(1'b1, 2'b01, 4'd3, 4'($urandom), acc);
    repeat (9) begin
      testsRun++; if ({s1, s0} !== expSel(cyc)) begin testsFailed++; $display("[TB] FAIL ror_sel c%0d: got %b expected %b", cyc, {s1, s0}, expSel(cyc)); end
      testsRun++; if (p_in !== expP(cyc)) begin testsFailed++; $display("[TB] FAIL ror_pin c%0d: got %b expected %b", cyc, p_in, expP(cyc)); end
      testsRun++; if (done !== expDone(cyc)) begin testsFailed++; $display("[TB] FAIL ror_done c%0d: got %b expected %b", cyc, done, expDone(cyc)); end
      if ({s1, s0} === 2'b01) runCount++;
      drive(1'b0, 2'b00, 4'h0, 4'h0, acc);
    end
    testsRun++; if (runCount != 3) begin testsFailed++; $display("[TB] FAIL ror_cycles: got %0d expected 3", runCount); end
    testsRun++; if (usrQ !== 4'b0001) begin testsFailed++; $display("[TB] FAIL ror_usr: got %b expected 0001", usrQ); end
    testsRun++; if (doneSeen != 2) begin testsFailed++; $display("[TB] FAIL ror_donecount: got %0d expected 2", doneSeen); end
  endtask

  task automatic test_zero_count();
    logic acc;
    doReset();
    drive(1'b1, 2'b10, 4'd0, 4'($urandom), acc);
    repeat (5) begin
      testsRun++; if ({s1, s0} !== 2'b00) begin testsFailed++; $display("[TB] FAIL zero_sel c%0d: got %b expected 00", cyc, {s1, s0}); end
      testsRun++; if (done !== (cyc == 2)) begin testsFailed++; $display("[TB] FAIL zero_done c%0d: got %b expected %b", cyc, done, (cyc == 2)); end
      drive(1'b0, 2'b00, 4'h0, 4'h0, acc);
    end
    testsRun++; if (doneSeen != 1) begin testsFailed++; $display("[TB] FAIL zero_donecount: got %0d expected 1", doneSeen); end
  endtask

  task automatic test_backpressure();
    logic acc;
    int accepted = 0;
    int firstLowAt = -1;
    int fifthCycle = -1;
    int thisCyc = 0;
    int guard;
    doReset();
    drive(1'b1, 2'b01, 4'd15, 4'($urandom), acc);
    for (int j = 0; j < 5; j++) begin
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 40) begin
        testsRun++; if (cmd_ready !== expReady(cyc)) begin testsFailed++; $display("[TB] FAIL bp_ready c%0d: got %b expected %b", cyc, cmd_ready, expReady(cyc)); end
        if (cmd_ready === 1'b0 && firstLowAt < 0) firstLowAt = accepted;
        thisCyc = cyc;
        drive(1'b1, 2'($urandom_range(1, 3)), 4'($urandom_range(1, 3)), 4'($urandom), acc);
        guard++;
      end
      if (acc) begin
        accepted++;
        if (j == 4) fifthCycle = thisCyc;
      end
    end
    testsRun++; if (accepted != 5) begin testsFailed++; $display("[TB] FAIL bp_accepted: got %0d expected 5", accepted); end
    testsRun++; if (firstLowAt != 4) begin testsFailed++; $display("[TB] FAIL bp_drop: got %0d expected 4", firstLowAt); end
    testsRun++; if (fifthCycle != 19) begin testsFailed++; $display("[TB] FAIL bp_fifth: got %0d expected 19", fifthCycle); end
    repeat (40) begin
      testsRun++; if ({s1, s0} !== expSel(cyc)) begin testsFailed++; $display("[TB] FAIL bp_sel c%0d: got %b expected %b", cyc, {s1, s0}, expSel(cyc)); end
      testsRun++; if (p_in !== expP(cyc)) begin testsFailed++; $display("[TB] FAIL bp_pin c%0d: got %b expected %b", cyc, p_in, expP(cyc)); end
      testsRun++; if (done !== expDone(cyc)) begin testsFailed++; $display("[TB] FAIL bp_done c%0d: got %b expected %b", cyc, done, expDone(cyc)); end
      drive(1'b0, 2'b00, 4'h0, 4'h0, acc);
    end
  endtask

  task automatic test_mid_reset();
    logic acc;
    doReset();
    drive(1'b1, 2'b10, 4'd7, 4'($urandom), acc);
    drive(1'b1, 2'($urandom_range(1, 3)), 4'($urandom_range(1, 15)), 4'($urandom), acc);
    drive(1'b1, 2'($urandom_range(1, 3)), 4'($urandom_range(1, 15)), 4'($urandom), acc);
    drive(1'b0, 2'b00, 4'h0, 4'h0, acc);
    testsRun++; if ({s1, s0} !== 2'b10) begin testsFailed++; $display("[TB] FAIL mid_run_sel: got %b expected 10", {s1, s0}); end
    doReset();
    testsRun++; if ({s1, s0} !== 2'b00) begin testsFailed++; $display("[TB] FAIL mid_sel: got %b expected 00", {s1, s0}); end
    testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_done: got %b expected 0", done); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    testsRun++; if (cmd_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_ready: got %b expected 1", cmd_ready); end
    repeat (20) begin
      testsRun++; if ({s1, s0, done, busy} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL mid_quiet c%0d: got %b expected 0000", cyc, {s1, s0, done, busy}); end
      drive(1'b0, 2'b00, 4'h0, 4'h0, acc);
    end
  endtask

  task automatic test_random();
    logic       acc;
    logic       v;
    int         sent = 0;
    int         guard = 0;
    int         mism = 0;
    logic [1:0] obsSeq[$];
    logic [1:0] expSeq[$];
    doReset();
    while ((sent < 40 || expBusy(cyc)) && guard < 4000) begin
      testsRun++; if ({s1, s0} !== expSel(cyc)) begin testsFailed++; $display("[TB] FAIL rnd_sel c%0d: got %b expected %b", cyc, {s1, s0}, expSel(cyc)); end
      testsRun++; if (p_in !== expP(cyc)) begin testsFailed++; $display("[TB] FAIL rnd_pin c%0d: got %b expected %b", cyc, p_in, expP(cyc)); end
      testsRun++; if (done !== expDone(cyc)) begin testsFailed++; $display("[TB] FAIL rnd_done c%0d: got %b expected %b", cyc, done, expDone(cyc)); end
      testsRun++; if (busy !== expBusy(cyc)) begin testsFailed++; $display("[TB] FAIL rnd_busy c%0d: got %b expected %b", cyc, busy, expBusy(cyc)); end
      testsRun++; if (cmd_ready !== expReady(cyc)) begin testsFailed++; $display("[TB] FAIL rnd_ready c%0d: got %b expected %b", cyc, cmd_ready, expReady(cyc)); end
      if ({s1, s0} !== 2'b00) obsSeq.push_back({s1, s0});
      v = (sent < 40) && ($urandom_range(0, 3) != 0);
      drive(v, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom), acc);
      if (acc) sent++;
      guard++;
    end
    testsRun++; if (guard >= 4000) begin testsFailed++; $display("[TB] FAIL rnd_timeout: got %0d cycles expected under 4000", guard); end
    foreach (qOp[i]) if (qOp[i] != 2'b00) repeat (qEff[i]) expSeq.push_back(qOp[i]);
    testsRun++;
    if (obsSeq.size() != expSeq.size()) begin
      testsFailed++; $display("[TB] FAIL rnd_seqlen: got %0d expected %0d", obsSeq.size(), expSeq.size());
    end else begin
      foreach (obsSeq[i]) if (obsSeq[i] !== expSeq[i]) mism++;
      testsRun++; if (mism != 0) begin testsFailed++; $display("[TB] FAIL rnd_seq: got %0d differing entries expected 0", mism); end
    end
    testsRun++; if (doneSeen != 40) begin testsFailed++; $display("[TB] FAIL rnd_donecount: got %0d expected 40", doneSeen); end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_cnt = 4'h0;
    cmd_data = 4'h0;
    test_reset();
    test_load();
    test_rotate();
    test_zero_count();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/usr_sequencer.md
USR_SEQUENCER -- requirements
Module: usr_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, 2 to 16.
REQ-002 Parameter CNT_W, default 4, width of the repeat-count field.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command FIFO can accept; transfer when cmd_valid && cmd_ready.
REQ-007 cmd_op  input  2  00 hold, 01 rotate right, 10 rotate left, 11 parallel load.
REQ-008 cmd_cnt  input  CNT_W  number of cycles to apply cmd_op.
REQ-009 cmd_data  input  4  parallel-load value.
REQ-010 s1  output  1  shift-register mode select, MSB.
REQ-011 s0  output  1  shift-register mode select, LSB.
REQ-012 p_in  output  4  parallel data to the shift register.
REQ-013 busy  output  1  high while the FSM is not IDLE or the FIFO is non-empty.
REQ-014 done  output  1  one-cycle pulse when a command completes.

Function
REQ-015 Commands are buffered in a FIFO_DEPTH-entry FIFO in order {op, cnt, data}; cmd_ready = !full, with no same-cycle pop credit.
REQ-016 Push when full is impossible (cmd_ready=0); push and pop in the same cycle when non-full and non-empty both occur, and the count is unchanged.
REQ-017 The FSM has states IDLE, RUN and DONE.
REQ-018 In IDLE with FIFO non-empty, the FSM pops one entry and latches op, cnt and data; it goes to RUN if the effective count > 0, else to DONE.
REQ-019 The effective count is cmd_cnt for ops 00/01/10 and is forced to 1 for op 11.
REQ-020 In RUN, {s1,s0} = latched op and p_in = latched data for exactly the effective count consecutive cycles, starting the cycle after the pop.
REQ-021 Within RUN, the counter decrements each cycle, and the FSM goes to DONE after the last cycle.
REQ-022 In DONE, done=1 for one cycle and {s1,s0}=00, then the FSM returns to IDLE.
REQ-023 Back-to-back commands therefore have a 2-cycle gap (DONE, IDLE-pop) between RUN phases.
REQ-024 Outside RUN, {s1,s0}=00 (hold), and p_in holds its last latched value (0 after reset).
REQ-025 cnt = 0 with op ≠ 11 produces no RUN cycles, but done still pulses.
REQ-026 Maximum count is 2^CNT_W-1 with no wrap; the counter never decrements below 0.
REQ-027 Inputs offered while cmd_ready=0 are ignored, and the FIFO contents are unaffected.

Reset
REQ-028 On rst=1 at a clock edge: FIFO is emptied, FSM goes to IDLE, counter=0, s1=s0=0, p_in=0, done=0, busy=0, and cmd_ready=1 in the cycle after reset.
REQ-029 Reset asserted mid-RUN aborts the command without a done pulse, and all queued commands are discarded.

Structure
REQ-030 Shared package usr_pkg holds the op encodings (OP_HOLD, OP_ROR, OP_ROL, OP_LOAD) and the FSM state enum.
REQ-031 The FIFO is a sub-module usr_cmd_fifo (synchronous, FIFO_DEPTH and width parameters, full/empty flags).
REQ-032 The FSM and counter live in usr_sequencer, whose outputs are registered.

Verification
REQ-033 Push {11,x,1011} -> RUN for 1 cycle with s1s0=11, p_in=1011, done one cycle later; a usr model fed s1/s0/p_in reads 1011.
REQ-034 Load 1000, then {01,3} -> s1s0=01 for exactly 3 cycles; model reads 0001, and done pulses once per command.
REQ-035 Push 5 commands with cmd_valid held while the FSM is stalled on a cnt=15 command -> cmd_ready drops after 4 accepted, and the 5th is accepted only after the first pop.
REQ-036 {10,0,x} -> no cycle with s1s0≠00, and done pulses 2 cycles after the push.
REQ-037 Assert rst during RUN of {10,7} at cycle 3 -> s1s0=00 next cycle, no done, FIFO empty, and busy=0.
REQ-038 Random push/cnt stream against a scoreboard -> the op/cycle sequence on s1/s0 matches the command order exactly.
